ddr_app_arbiter: RTL

- Upstream stage of the MIG-based DDR3 controller. Arbitrates the PSC, DSC and L2 request ports and issues one 128-bit transaction at a time on the MIG user (app_*) interface.
- Each transaction is one BL8 x16 burst (one app command, one write-data beat).
- Latches address and write data at grant, sequences the app_en / app_wdf_wren handshakes, captures read data and returns it with a per-master done pulse.

---
 rtl/ddr_app_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ddr_app_arbiter.sv
// ddr_app_arbiter
//   Arbitrates the PSC, DSC and L2 request ports onto the MIG user (app_*)
//   interface. Runs one single-beat (BL8 x16, 128-bit) transaction at a time.
//   At grant it latches the winner's rw, address and write data. It then runs
//   the app_en / app_wdf_wren handshakes, captures read data, and returns a
//   done pulse to the owner.
//
//   Optional build macro: DDR_ARB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration. The search starts at the master
//                  after the last owner; the last owner resets to L2.
//     undefined -> fixed priority PSC > DSC > L2.
//
// Ports
//   clk_166M66, mcu_sys_rst      MIG ui_clk, synchronous active-high reset
//   i_init_calib_complete        no grants while low
//   i_<m>_request/rw/addr/wdata  per-master request (m = psc, dsc, l2)
//   o_<m>_bus_available          grant, high for the whole transaction
//   o_<m>_done                   one-cycle completion pulse
//   o_rd_data, o_error, o_busy   read data, read-timeout pulse, not-idle
//   o_app_* / i_app_*            MIG user interface
//
// state  | meaning
// IDLE   | waiting for calibration and a request; grants the winner
// CMD    | app command (and write data for writes) being offered to the MIG
// RDWAIT | read accepted; waiting for app_rd_data_valid or the timeout
// DONE   | one cycle; the owner's done pulse is high
module ddr_app_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                    clk_166M66,
  input  logic                    mcu_sys_rst,
  input  logic                    i_init_calib_complete,
  input  logic                    i_psc_request,
  input  logic                    i_dsc_request,
  input  logic                    i_l2_request,
  input  logic                    i_psc_rw,
  input  logic                    i_dsc_rw,
  input  logic                    i_l2_rw,
  input  logic [ADDR_WIDTH-1:0]   i_psc_addr,
  input  logic [ADDR_WIDTH-1:0]   i_dsc_addr,
  input  logic [ADDR_WIDTH-1:0]   i_l2_addr,
  input  logic [DATA_WIDTH-1:0]   i_psc_wdata,
  input  logic [DATA_WIDTH-1:0]   i_dsc_wdata,
  input  logic [DATA_WIDTH-1:0]   i_l2_wdata,
  output logic                    o_psc_bus_available,
  output logic                    o_dsc_bus_available,
  output logic                    o_l2_bus_available,
  output logic                    o_psc_done,
  output logic                    o_dsc_done,
  output logic                    o_l2_done,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic                    o_error,
  output logic                    o_busy,
  output logic [ADDR_WIDTH-1:0]   o_app_addr,
  output logic [2:0]              o_app_cmd,
  output logic                    o_app_en,
  input  logic                    i_app_rdy,
  output logic [DATA_WIDTH-1:0]   o_app_wdf_data,
  output logic                    o_app_wdf_wren,
  output logic                    o_app_wdf_end,
  output logic [DATA_WIDTH/8-1:0] o_app_wdf_mask,
  input  logic                    i_app_wdf_rdy,
  input  logic [DATA_WIDTH-1:0]   i_app_rd_data,
  input  logic                    i_app_rd_data_valid,
  input  logic                    i_app_rd_data_end
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_RDWAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PSC, OWN_DSC, OWN_L2} owner_t;

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  rw_q, rw_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cmd_acc_q, cmd_acc_d;
  logic                  wdf_acc_q, wdf_acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  app_en_q, app_en_d;
  logic                  wdf_wren_q, wdf_wren_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [2:0]            avail_q, avail_d;
  logic [2:0]            done_q, done_d;
  logic                  error_q, error_d;

  owner_t                winner;
  logic                  sel_rw;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  cmd_hs, wdf_hs;

  function automatic logic [2:0] owner_onehot(input owner_t o);
    case (o)
      OWN_PSC: return 3'b001;
      OWN_DSC: return 3'b010;
      OWN_L2:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

`ifdef DDR_ARB_ROUND_ROBIN_EN
  owner_t last_q, last_d;

  always_comb begin
    winner = OWN_NONE;
    case (last_q)
      OWN_PSC: begin
        if      (i_dsc_request) winner = OWN_DSC;
        else if (i_l2_request)  winner = OWN_L2;
        else if (i_psc_request) winner = OWN_PSC;
      end
      OWN_DSC: begin
        if      (i_l2_request)  winner = OWN_L2;
        else if (i_psc_request) winner = OWN_PSC;
        else if (i_dsc_request) winner = OWN_DSC;
      end
      default: begin
        if      (i_psc_request) winner = OWN_PSC;
        else if (i_dsc_request) winner = OWN_DSC;
        else if (i_l2_request)  winner = OWN_L2;
      end
    endcase
  end
`else
  always_comb begin
    winner = OWN_NONE;
    if      (i_psc_request) winner = OWN_PSC;
    else if (i_dsc_request) winner = OWN_DSC;
    else if (i_l2_request)  winner = OWN_L2;
  end
`endif

  always_comb begin
    sel_rw    = i_psc_rw;
    sel_addr  = i_psc_addr;
    sel_wdata = i_psc_wdata;
    case (winner)
      OWN_DSC: begin
        sel_rw    = i_dsc_rw;
        sel_addr  = i_dsc_addr;
        sel_wdata = i_dsc_wdata;
      end
      OWN_L2: begin
        sel_rw    = i_l2_rw;
        sel_addr  = i_l2_addr;
        sel_wdata = i_l2_wdata;
      end
      default: ;
    endcase
  end

  assign cmd_hs = app_en_q & i_app_rdy;
  assign wdf_hs = wdf_wren_q & i_app_wdf_rdy;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cmd_acc_d  = cmd_acc_q;
    wdf_acc_d  = wdf_acc_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    app_en_d   = app_en_q;
    wdf_wren_d = wdf_wren_q;
    app_cmd_d  = app_cmd_q;
    avail_d    = avail_q;
    done_d     = 3'b000;
    error_d    = 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
    last_d     = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_init_calib_complete && (winner != OWN_NONE)) begin
          owner_d    = winner;
          rw_d       = sel_rw;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          avail_d    = owner_onehot(winner);
          app_en_d   = 1'b1;
          wdf_wren_d = sel_rw;
          app_cmd_d  = sel_rw ? 3'b000 : 3'b001;
          cmd_acc_d  = 1'b0;
          wdf_acc_d  = 1'b0;
          state_d    = S_CMD;
`ifdef DDR_ARB_ROUND_ROBIN_EN
          last_d     = winner;
`endif
        end
      end
      S_CMD: begin
        if (cmd_hs) begin
          app_en_d  = 1'b0;
          cmd_acc_d = 1'b1;
        end
        if (wdf_hs) begin
          wdf_wren_d = 1'b0;
          wdf_acc_d  = 1'b1;
        end
        if (!rw_q) begin
          if (cmd_hs) begin
            cnt_d   = '0;
            state_d = S_RDWAIT;
          end
        end else if ((cmd_acc_q | cmd_hs) && (wdf_acc_q | wdf_hs)) begin
          // Command and data handshakes may complete in either order.
          done_d  = owner_onehot(owner_q);
          state_d = S_DONE;
        end
      end
      S_RDWAIT: begin
        // Valid takes precedence, so data on the last allowed cycle is a success.
        if (i_app_rd_data_valid) begin
          rd_data_d = i_app_rd_data;
          done_d    = owner_onehot(owner_q);
          state_d   = S_DONE;
        end else if (cnt_q == CNT_W'(RD_TIMEOUT - 1)) begin
          error_d = 1'b1;
          done_d  = owner_onehot(owner_q);
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        avail_d = 3'b000;
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_166M66) begin
    if (mcu_sys_rst) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_NONE;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cmd_acc_q  <= 1'b0;
      wdf_acc_q  <= 1'b0;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      app_en_q   <= 1'b0;
      wdf_wren_q <= 1'b0;
      app_cmd_q  <= 3'b000;
      avail_q    <= 3'b000;
      done_q     <= 3'b000;
      error_q    <= 1'b0;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_q     <= OWN_L2;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cmd_acc_q  <= cmd_acc_d;
      wdf_acc_q  <= wdf_acc_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      app_en_q   <= app_en_d;
      wdf_wren_q <= wdf_wren_d;
      app_cmd_q  <= app_cmd_d;
      avail_q    <= avail_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef DDR_ARB_ROUND_ROBIN_EN
      last_q     <= last_d;
`endif
    end
  end

  // Every read is a single beat, so end must always accompany valid.
  a_rd_end: assert property (@(posedge clk_166M66) disable iff (mcu_sys_rst)
                             i_app_rd_data_valid |-> i_app_rd_data_end);

  assign o_psc_bus_available = avail_q[0];
  assign o_dsc_bus_available = avail_q[1];
  assign o_l2_bus_available  = avail_q[2];
  assign o_psc_done          = done_q[0];
  assign o_dsc_done          = done_q[1];
  assign o_l2_done           = done_q[2];
  assign o_rd_data           = rd_data_q;
  assign o_error             = error_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_app_addr          = addr_q;
  assign o_app_cmd           = app_cmd_q;
  assign o_app_en            = app_en_q;
  assign o_app_wdf_data      = wdata_q;
  assign o_app_wdf_wren      = wdf_wren_q;
  assign o_app_wdf_end       = wdf_wren_q;
  assign o_app_wdf_mask      = '0;

endmodule
